// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
//
// Sequencing controller for the five-stage pipeline. It drives the PC enable
// and the enable/flush pairs of the IF/ID, ID/EX, EX/MEM and MEM/WB latches.
// It resolves these events in priority order:
//   1. memory-wait freezes
//   2. halt
//   3. control-transfer redirects
//   4. load-use stalls
//   5. instruction-fetch misses
// It also keeps a saturating stall-cycle counter for performance debug.
//
// Ports
//   CLK, nRST                 clock (rising edge), async active-low reset
//   ihit, dhit                fetch / data access completed this cycle
//   exmem_dREN, exmem_dWEN    load / store held in EX/MEM
//   exmem_halt                halt instruction held in EX/MEM
//   idex_dREN, idex_wsel      load and its destination register in ID/EX
//   ifid_rs, ifid_rt          source registers of the IF/ID instruction
//   ex_redirect               EX resolved a taken branch or jump
//   pc_en                     PC load enable                    (Mealy)
//   *_en, *_flush             latch enables and clears          (Mealy)
//   halted                    registered halt indication
//   stall_count               saturating count of stalled cycles
// -----------------------------------------------------------------------------
module pipeline_ctrl (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic        dhit,
    input  logic        exmem_dREN,
    input  logic        exmem_dWEN,
    input  logic        exmem_halt,
    input  logic        idex_dREN,
    input  logic [4:0]  idex_wsel,
    input  logic [4:0]  ifid_rs,
    input  logic [4:0]  ifid_rt,
    input  logic        ex_redirect,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        exmem_en,
    output logic        memwb_en,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        exmem_flush,
    output logic        halted,
    output logic [15:0] stall_count
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        HALT    = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        halted_q;
    logic [15:0] count_q, count_d;

    logic mem_busy;
    logic load_use;
    logic freeze;

    assign mem_busy = (exmem_dREN | exmem_dWEN) & ~dhit;

    // Register 0 is hard-wired zero, so a load targeting it never creates a
    // real dependency.
    assign load_use = idex_dREN & (idex_wsel != 5'd0) &
                      ((idex_wsel == ifid_rs) | (idex_wsel == ifid_rt));

    // Once waiting, the freeze is held purely by the outstanding data access.
    assign freeze = (state_q == MEMWAIT) ? ~dhit : mem_busy;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            HALT: state_d = HALT;
            default: begin
                if (freeze) begin
                    state_d = MEMWAIT;
                end else if (exmem_halt) begin
                    state_d = HALT;
                end else begin
                    state_d = RUN;
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic (Mealy). Everything defaults to 0, which is the
    // reset, freeze and halt pattern alike.
    // ------------------------------------------------------------------
    // NOTE: every output gets a default before any branch so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;

        if (nRST && (state_q != HALT) && !freeze) begin
            pc_en    = 1'b1;
            ifid_en  = 1'b1;
            idex_en  = 1'b1;
            exmem_en = 1'b1;
            memwb_en = 1'b1;
            if (exmem_halt) begin
                // Drain: the halt retires; everything younger is squashed.
                pc_en       = 1'b0;
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                exmem_flush = 1'b1;
            end else if (ex_redirect) begin
                // The squash also covers any load-use or fetch-miss case.
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (load_use) begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
            end else if (!ihit) begin
                pc_en      = 1'b0;
                ifid_flush = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Halt flag and stall counter
    // ------------------------------------------------------------------
    always_comb begin
        count_d = count_q;
        if ((state_q != HALT) && !pc_en && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            halted_q <= 1'b0;
            count_q  <= 16'd0;
        end else begin
            halted_q <= (state_d == HALT);
            count_q  <= count_d;
        end
    end

    assign halted      = halted_q;
    assign stall_count = count_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_ctrl
//
// Self-checking bench for pipeline_ctrl.
//
// A behavioural reference model derives the expected enables and flushes
// directly from the priority rules. It also tracks three things:
//   - whether a data access is still outstanding
//   - whether the pipe has halted
//   - the stall count
// Directed scenarios are followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_pipeline_ctrl;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        ihit, dhit;
    logic        exmem_dREN, exmem_dWEN, exmem_halt;
    logic        idex_dREN;
    logic [4:0]  idex_wsel, ifid_rs, ifid_rt;
    logic        ex_redirect;
    logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic        ifid_flush, idex_flush, exmem_flush;
    logic        halted;
    logic [15:0] stall_count;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit m_waiting;   // a data access is outstanding
    bit m_halt;      // pipe has accepted a halt
    int m_count;     // stalled cycles so far, saturating at 65535

    pipeline_ctrl dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .ihit        (ihit),
        .dhit        (dhit),
        .exmem_dREN  (exmem_dREN),
        .exmem_dWEN  (exmem_dWEN),
        .exmem_halt  (exmem_halt),
        .idex_dREN   (idex_dREN),
        .idex_wsel   (idex_wsel),
        .ifid_rs     (ifid_rs),
        .ifid_rt     (ifid_rt),
        .ex_redirect (ex_redirect),
        .pc_en       (pc_en),
        .ifid_en     (ifid_en),
        .idex_en     (idex_en),
        .exmem_en    (exmem_en),
        .memwb_en    (memwb_en),
        .ifid_flush  (ifid_flush),
        .idex_flush  (idex_flush),
        .exmem_flush (exmem_flush),
        .halted      (halted),
        .stall_count (stall_count)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Output bundle order:
    //   {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
    //    ifid_flush, idex_flush, exmem_flush}
    function automatic logic [7:0] outs();
        return {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                ifid_flush, idex_flush, exmem_flush};
    endfunction

    function automatic bit model_freeze();
        if (m_waiting) return !dhit;
        return (exmem_dREN || exmem_dWEN) && !dhit;
    endfunction

    function automatic logic [7:0] model_outs();
        bit lu;
        lu = idex_dREN && (idex_wsel != 0) &&
             (idex_wsel == ifid_rs || idex_wsel == ifid_rt);
        if (m_halt)          return 8'b0_0000_000;
        if (model_freeze())  return 8'b0_0000_000;
        if (exmem_halt)      return 8'b0_1111_111;
        if (ex_redirect)     return 8'b1_1111_110;
        if (lu)              return 8'b0_0111_010;
        if (!ihit)           return 8'b0_1111_100;
        return 8'b1_1111_000;
    endfunction

    task automatic idle_inputs();
        ihit = 1'b1; dhit = 1'b0;
        exmem_dREN = 1'b0; exmem_dWEN = 1'b0; exmem_halt = 1'b0;
        idex_dREN = 1'b0; idex_wsel = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
        ex_redirect = 1'b0;
    endtask

    // One clock. The caller sets inputs just after a rising edge. This task:
    //   - checks the Mealy and registered outputs on the falling edge
    //   - advances the model at the rising edge
    task automatic cycle(input string tag);
        logic [7:0] exp;
        bit fr;
        @(negedge CLK);
        exp = model_outs();
        fr  = model_freeze();
        check({tag, "_outs"},   {24'd0, outs()},        {24'd0, exp});
        check({tag, "_halted"}, {31'd0, halted},        {31'd0, m_halt});
        check({tag, "_count"},  {16'd0, stall_count},   m_count);
        @(posedge CLK);
        if (!m_halt && !exp[7] && m_count < 65535) m_count++;
        if (!m_halt) begin
            m_waiting = fr;
            m_halt    = !fr && exmem_halt;
        end
        #1;
    endtask

    // Asserts reset asynchronously, checks the immediate effect, releases.
    task automatic do_reset(input string tag);
        nRST = 1'b0;
        ihit = 1'b1; ex_redirect = 1'b1; exmem_halt = 1'b1;
        #1;
        check({tag, "_rst_outs"},   {24'd0, outs()},      32'd0);
        check({tag, "_rst_halted"}, {31'd0, halted},      32'd0);
        check({tag, "_rst_count"},  {16'd0, stall_count}, 32'd0);
        m_waiting = 1'b0; m_halt = 1'b0; m_count = 0;
        @(posedge CLK);
        #1;
        check({tag, "_rst_hold"}, {24'd0, outs()}, 32'd0);
        nRST = 1'b1;
        idle_inputs();
    endtask

    initial begin
        nRST = 1'b0;
        idle_inputs();
        m_waiting = 1'b0; m_halt = 1'b0; m_count = 0;
        #2;
        check("por_outs",   {24'd0, outs()},      32'd0);
        check("por_halted", {31'd0, halted},      32'd0);
        check("por_count",  {16'd0, stall_count}, 32'd0);
        @(posedge CLK);
        #1;
        nRST = 1'b1;

        // Load-use: one-cycle bubble, count 0 -> 1.
        idle_inputs();
        idex_dREN = 1'b1; idex_wsel = 5'd5; ifid_rs = 5'd5; ifid_rt = 5'd7;
        #1;
        check("lu_direct", {24'd0, outs()}, {24'd0, 8'b0_0111_010});
        cycle("lu");
        idle_inputs();
        check("lu_count", {16'd0, stall_count}, 32'd1);
        cycle("lu_after");

        // Load with rd=0 never stalls.
        idex_dREN = 1'b1; idex_wsel = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
        cycle("lu_r0");
        idle_inputs();

        // Memory wait: three frozen cycles, then release on dhit.
        exmem_dREN = 1'b1; dhit = 1'b0;
        for (int i = 0; i < 3; i++) cycle("memwait");
        check("memwait_count", {16'd0, stall_count}, 32'd4);
        dhit = 1'b1;
        #1;
        check("memwait_release", {24'd0, outs()}, {24'd0, 8'b1_1111_000});
        cycle("memwait_dhit");
        idle_inputs();
        cycle("memwait_after");

        // Redirect wins over load-use and over a fetch miss.
        ex_redirect = 1'b1; idex_dREN = 1'b1; idex_wsel = 5'd9; ifid_rt = 5'd9;
        ihit = 1'b0;
        #1;
        check("redir_direct", {24'd0, outs()}, {24'd0, 8'b1_1111_110});
        cycle("redir");
        idle_inputs();

        // Fetch miss bubble.
        ihit = 1'b0;
        cycle("imiss");
        idle_inputs();

        // Randomized phase, no halts.
        for (int i = 0; i < 3000; i++) begin
            ihit        = ($urandom_range(0, 3) != 0);
            dhit        = $urandom_range(0, 1);
            exmem_dREN  = ($urandom_range(0, 3) == 0);
            exmem_dWEN  = ($urandom_range(0, 5) == 0);
            exmem_halt  = 1'b0;
            idex_dREN   = $urandom_range(0, 1);
            idex_wsel   = 5'($urandom_range(0, 3));
            ifid_rs     = 5'($urandom_range(0, 3));
            ifid_rt     = 5'($urandom_range(0, 3));
            ex_redirect = ($urandom_range(0, 4) == 0);
            cycle("rand");
        end
        idle_inputs();

        // Halt: drain cycle, then ten frozen cycles under random inputs.
        exmem_halt = 1'b1;
        #1;
        check("halt_direct", {24'd0, outs()}, {24'd0, 8'b0_1111_111});
        cycle("halt");
        begin
            int frozen_count;
            frozen_count = int'(stall_count);
            for (int i = 0; i < 10; i++) begin
                ihit        = $urandom_range(0, 1);
                dhit        = $urandom_range(0, 1);
                exmem_dREN  = $urandom_range(0, 1);
                exmem_halt  = $urandom_range(0, 1);
                ex_redirect = $urandom_range(0, 1);
                cycle("halted");
                check("halted_flag", {31'd0, halted}, 32'd1);
            end
            check("halt_count_frozen", {16'd0, stall_count}, frozen_count);
        end

        // Reset out of HALT, then saturate the counter with a fetch miss.
        do_reset("halt");
        ihit = 1'b0;
        for (int i = 0; i < 70000; i++) cycle("sat");
        check("sat_count", {16'd0, stall_count}, 32'h0000_FFFF);
        idle_inputs();

        // Reset mid-MEMWAIT.
        exmem_dWEN = 1'b1; dhit = 1'b0;
        cycle("mw_pre");
        cycle("mw_pre");
        do_reset("memwait");
        cycle("post_reset");
        check("post_reset_count", {16'd0, stall_count}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
